// File: rtl/drum_sequencer_if.sv
// Control and status bundle between the drum sequencer and its consumer.
// The sequencer takes the slave modport; the controller takes master.
interface drum_sequencer_if;
  logic       run;
  logic       sample_tick;
  logic       kick_trig;
  logic       snare_trig;
  logic       hat_trig;
  logic       accent;
  logic [3:0] step;
  logic [7:0] bar;

  modport master (
    output run,
    input  sample_tick, kick_trig, snare_trig, hat_trig, accent, step, bar
  );

  modport slave (
    input  run,
    output sample_tick, kick_trig, snare_trig, hat_trig, accent, step, bar
  );
endinterface

// File: rtl/drum_sequencer.sv
// Fixed-pattern drum sequencer: sample-rate divider, step/bar counters and
// registered kick/snare/hi-hat triggers aligned to the sample tick.
module drum_sequencer #(
  parameter int unsigned SAMPLE_DIV   = 1024,
  parameter int unsigned STEP_SAMPLES = 4096
) (
  input  logic              clk48,
  input  logic              rst_n,
  drum_sequencer_if.slave   bus
);

  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned SAMP_W = $clog2(STEP_SAMPLES);

  logic [DIV_W-1:0]  div_q,  div_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [3:0]        step_q, step_d;
  logic [7:0]        bar_q,  bar_d;
  logic              tick_q,   tick_d;
  logic              kick_q,   kick_d;
  logic              snare_q,  snare_d;
  logic              hat_q,    hat_d;
  logic              accent_q, accent_d;

  logic ev;
  logic fill;

  // Both divider widths are powers of two, so plain increments wrap correctly.
  always_comb begin
    div_d    = div_q;
    samp_d   = samp_q;
    step_d   = step_q;
    bar_d    = bar_q;
    tick_d   = 1'b0;
    kick_d   = 1'b0;
    snare_d  = 1'b0;
    hat_d    = 1'b0;
    ev       = bus.run && (div_q == '0);
    fill     = (bar_q[3:0] == 4'hF);

    if (bus.run) begin
      div_d = div_q + DIV_W'(1);
    end

    if (ev) begin
      tick_d = 1'b1;
      samp_d = samp_q + SAMP_W'(1);
      if (samp_q == '1) begin
        step_d = step_q + 4'd1;
        if (step_q == 4'hF) begin
          bar_d = bar_q + 8'd1;
        end
      end
      // Pattern lookup uses the pre-increment step/bar of the first sample in a step.
      if (samp_q == '0) begin
        kick_d  = (step_q == 4'd0) || (step_q == 4'd8) ||
                  ((step_q == 4'd10) && bar_q[0]);
        snare_d = (step_q == 4'd4) || (step_q == 4'd12) ||
                  (fill && (step_q >= 4'd13));
        hat_d   = !step_q[0] && !(fill && (step_q >= 4'd12));
      end
    end

    accent_d = (step_d == 4'd0) || (step_d == 4'd8);
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      div_q    <= '0;
      samp_q   <= '0;
      step_q   <= '0;
      bar_q    <= '0;
      tick_q   <= 1'b0;
      kick_q   <= 1'b0;
      snare_q  <= 1'b0;
      hat_q    <= 1'b0;
      accent_q <= 1'b1;
    end else begin
      div_q    <= div_d;
      samp_q   <= samp_d;
      step_q   <= step_d;
      bar_q    <= bar_d;
      tick_q   <= tick_d;
      kick_q   <= kick_d;
      snare_q  <= snare_d;
      hat_q    <= hat_d;
      accent_q <= accent_d;
    end
  end

  assign bus.sample_tick = tick_q;
  assign bus.kick_trig   = kick_q;
  assign bus.snare_trig  = snare_q;
  assign bus.hat_trig    = hat_q;
  assign bus.accent      = accent_q;
  assign bus.step        = step_q;
  assign bus.bar         = bar_q;

endmodule

// File: tb/tb_drum_sequencer.sv
// Directed bench for drum_sequencer: pattern table over a full 256-bar wrap,
// run-gap hold, mid-step reset, and tick spacing at default parameters.
module tb_drum_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  drum_sequencer_if bus ();
  drum_sequencer_if bus_d ();

  drum_sequencer #(.SAMPLE_DIV(4), .STEP_SAMPLES(2)) dut (
    .clk48 (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  drum_sequencer dut_d (
    .clk48 (clk),
    .rst_n (rst_n),
    .bus   (bus_d)
  );

  int total = 0;
  int bad   = 0;
  int now   = 0;
  int abs_cyc = 0;
  int last_tick = -1000;

  typedef struct {
    int idx;
    int st;
    int br;
    int k;
    int s;
    int h;
    int a;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc_to(input int t);
    while (now < t) begin
      @(negedge clk);
      now++;
    end
  endtask

  function automatic int trigs();
    return {29'd0, bus.kick_trig, bus.snare_trig, bus.hat_trig};
  endfunction

  always @(posedge clk) abs_cyc++;

  // Triggers must ride on a tick, and ticks must be at least SAMPLE_DIV apart.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_tick = -1000;
    end else if (bus.sample_tick) begin
      chk("tick_spacing_ok", int'((abs_cyc - last_tick) >= 4), 1);
      last_tick = abs_cyc;
    end else begin
      chk("trig_without_tick", trigs(), 0);
    end
  end

  initial begin
    int t;
    int t0;
    int found;

    tbl[0]  = '{0,    0,  0,   1, 0, 1, 1};
    tbl[1]  = '{1,    1,  0,   0, 0, 0, 0};
    tbl[2]  = '{2,    2,  0,   0, 0, 1, 0};
    tbl[3]  = '{4,    4,  0,   0, 1, 1, 0};
    tbl[4]  = '{8,    8,  0,   1, 0, 1, 1};
    tbl[5]  = '{10,   10, 0,   0, 0, 1, 0};
    tbl[6]  = '{12,   12, 0,   0, 1, 1, 0};
    tbl[7]  = '{13,   13, 0,   0, 0, 0, 0};
    tbl[8]  = '{15,   15, 0,   0, 0, 0, 0};
    tbl[9]  = '{16,   0,  1,   1, 0, 1, 1};
    tbl[10] = '{26,   10, 1,   1, 0, 1, 0};
    tbl[11] = '{42,   10, 2,   0, 0, 1, 0};
    tbl[12] = '{248,  8,  15,  1, 0, 1, 1};
    tbl[13] = '{250,  10, 15,  1, 0, 1, 0};
    tbl[14] = '{252,  12, 15,  0, 1, 0, 0};
    tbl[15] = '{253,  13, 15,  0, 1, 0, 0};
    tbl[16] = '{254,  14, 15,  0, 1, 0, 0};
    tbl[17] = '{255,  15, 15,  0, 1, 0, 0};
    tbl[18] = '{256,  0,  16,  1, 0, 1, 1};
    tbl[19] = '{268,  12, 16,  0, 1, 1, 0};
    tbl[20] = '{510,  14, 31,  0, 1, 0, 0};
    tbl[21] = '{4090, 10, 255, 1, 0, 1, 0};
    tbl[22] = '{4093, 13, 255, 0, 1, 0, 0};
    tbl[23] = '{4095, 15, 255, 0, 1, 0, 0};
    tbl[24] = '{4096, 0,  0,   1, 0, 1, 1};

    // Reset with run high: reset must win.
    rst_n = 1'b0;
    bus.run = 1'b1;
    bus_d.run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tick",   int'(bus.sample_tick), 0);
    chk("rst_trigs",  trigs(), 0);
    chk("rst_accent", int'(bus.accent), 1);
    chk("rst_step",   int'(bus.step), 0);
    chk("rst_bar",    int'(bus.bar), 0);

    rst_n = 1'b1;
    now = 0;

    // Step idx's first-sample tick lands at 1+8*idx; its wrap tick 4 cycles earlier.
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].idx > 0) begin
        cyc_to(8 * tbl[i].idx - 3);
        chk($sformatf("wrap_tick[%0d]", tbl[i].idx), int'(bus.sample_tick), 1);
        chk($sformatf("wrap_trigs[%0d]", tbl[i].idx), trigs(), 0);
        chk($sformatf("wrap_step[%0d]", tbl[i].idx), int'(bus.step), tbl[i].st);
        cyc_to(8 * tbl[i].idx - 2);
        chk($sformatf("gap_tick[%0d]", tbl[i].idx), int'(bus.sample_tick), 0);
      end
      cyc_to(8 * tbl[i].idx + 1);
      chk($sformatf("tick[%0d]", tbl[i].idx),   int'(bus.sample_tick), 1);
      chk($sformatf("kick[%0d]", tbl[i].idx),   int'(bus.kick_trig), tbl[i].k);
      chk($sformatf("snare[%0d]", tbl[i].idx),  int'(bus.snare_trig), tbl[i].s);
      chk($sformatf("hat[%0d]", tbl[i].idx),    int'(bus.hat_trig), tbl[i].h);
      chk($sformatf("accent[%0d]", tbl[i].idx), int'(bus.accent), tbl[i].a);
      chk($sformatf("step[%0d]", tbl[i].idx),   int'(bus.step), tbl[i].st);
      chk($sformatf("bar[%0d]", tbl[i].idx),    int'(bus.bar), tbl[i].br);
    end

    // Run gap: drop run for 7 edges mid-step, phase must resume exactly.
    t = now;
    cyc_to(t + 1);
    bus.run = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      cyc_to(t + k);
      chk("hold_tick",   int'(bus.sample_tick), 0);
      chk("hold_trigs",  trigs(), 0);
      chk("hold_step",   int'(bus.step), 0);
      chk("hold_bar",    int'(bus.bar), 0);
      chk("hold_accent", int'(bus.accent), 1);
    end
    bus.run = 1'b1;
    cyc_to(t + 10);
    chk("resume_no_early_tick", int'(bus.sample_tick), 0);
    cyc_to(t + 11);
    chk("resume_tick",  int'(bus.sample_tick), 1);
    chk("resume_trigs", trigs(), 0);
    chk("resume_step",  int'(bus.step), 1);
    cyc_to(t + 23);
    chk("resume2_tick", int'(bus.sample_tick), 1);
    chk("resume2_hat",  int'(bus.hat_trig), 1);
    chk("resume2_kick", int'(bus.kick_trig), 0);
    chk("resume2_step", int'(bus.step), 2);

    // Mid-step reset at bar 3 step 9.
    rst_n = 1'b0;
    cyc_to(now + 2);
    rst_n = 1'b1;
    now = 0;
    cyc_to(457);
    chk("pre_rst_tick", int'(bus.sample_tick), 1);
    chk("pre_rst_step", int'(bus.step), 9);
    chk("pre_rst_bar",  int'(bus.bar), 3);
    chk("pre_rst_trig", trigs(), 0);
    cyc_to(459);
    rst_n = 1'b0;
    cyc_to(460);
    chk("mid_rst_tick",   int'(bus.sample_tick), 0);
    chk("mid_rst_trigs",  trigs(), 0);
    chk("mid_rst_accent", int'(bus.accent), 1);
    chk("mid_rst_step",   int'(bus.step), 0);
    chk("mid_rst_bar",    int'(bus.bar), 0);
    rst_n = 1'b1;
    now = 0;
    cyc_to(1);
    chk("post_rst_tick",   int'(bus.sample_tick), 1);
    chk("post_rst_kick",   int'(bus.kick_trig), 1);
    chk("post_rst_hat",    int'(bus.hat_trig), 1);
    chk("post_rst_snare",  int'(bus.snare_trig), 0);
    chk("post_rst_step",   int'(bus.step), 0);
    chk("post_rst_bar",    int'(bus.bar), 0);
    chk("post_rst_accent", int'(bus.accent), 1);

    // Default parameters: consecutive ticks 1024 cycles apart, step still 0.
    t0 = -1;
    found = 0;
    for (int c = 0; c < 3000 && found < 2; c++) begin
      if (bus_d.sample_tick) begin
        if (found == 1) chk("def_tick_spacing", now - t0, 1024);
        t0 = now;
        found++;
      end
      if (found < 2) cyc_to(now + 1);
    end
    chk("def_two_ticks_seen", found, 2);
    chk("def_step_held", int'(bus_d.step), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
